ram_read_scheduler: RTL

- Sequences all accesses to the dual-read/single-write program block RAM for the out-of-order core.
- Arbitrates two read requesters (0 = fetch, 1 = load) into a small in-order pending queue.
- Issues up to two queued reads per cycle onto the RAM's two combinational read ports and returns tagged responses.
- Passes a single write channel straight to the RAM write port, with write-to-read forwarding.

---
 rtl/ram_read_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ram_read_scheduler.sv
// ram_read_scheduler: arbitrates two read requesters into an in-order queue and issues up to two reads per cycle.
// Optional RAM_SCHED_STATS_EN builds saturating issue/stall counters; otherwise the stat ports are tied to 0.
module ram_read_scheduler #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TAG_W       = 4,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*TAG_W-1:0]    req_tag,
    input  logic                  wr_valid,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_waddr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [ADDR_W-1:0]     ram_raddr0,
    input  logic [DATA_W-1:0]     ram_rdata0,
    output logic [ADDR_W-1:0]     ram_raddr1,
    input  logic [DATA_W-1:0]     ram_rdata1,
    output logic [1:0]            rsp_valid,
    output logic [1:0]            rsp_src,
    output logic [2*TAG_W-1:0]    rsp_tag,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_stalls
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_FLUSH = 2'd2;

    logic [ADDR_W-1:0] addr_q [QUEUE_DEPTH];
    logic [TAG_W-1:0]  tag_q  [QUEUE_DEPTH];
    logic              src_q  [QUEUE_DEPTH];
    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, h1, t1;
    logic [CW-1:0]     count_q, count_d, free, n_enq, n_deq;
    logic              rr_q, rr_d, iss0, iss1;
    logic [1:0]        grant, rsp_valid_d;
    logic [1:0]        rsp_valid_q, rsp_src_q, rsp_src_d;
    logic [2*TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic [2*DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] d0, d1;

    assign ram_we    = wr_valid;
    assign ram_waddr = wr_addr;
    assign ram_wdata = wr_data;

    assign free  = CW'(QUEUE_DEPTH) - count_q;
    assign h1    = head_q + PW'(1);
    assign t1    = tail_q + PW'(1);
    assign grant = req_valid & req_ready;
    assign n_enq = CW'(grant[0]) + CW'(grant[1]);
    assign iss0  = state_q == S_ACTIVE && count_q != '0;
    assign iss1  = state_q == S_ACTIVE && count_q > CW'(1);
    assign n_deq = CW'(iss0) + CW'(iss1);

    assign ram_raddr0 = iss0 ? addr_q[head_q] : '0;
    assign ram_raddr1 = iss1 ? addr_q[h1] : '0;

    // With one free slot only a contended pair is narrowed to the round-robin winner.
    always_comb begin
        req_ready = 2'b00;
        if (!rst && !flush && state_q != S_FLUSH)
            req_ready = free >= CW'(2) ? 2'b11 :
                        free == CW'(1) ? (&req_valid ? (rr_q ? 2'b10 : 2'b01) : 2'b11) : 2'b00;
    end

    // A same-cycle write is older than the read, so it wins on an address match.
    always_comb begin
        d0          = wr_valid && wr_addr == ram_raddr0 ? wr_data : ram_rdata0;
        d1          = wr_valid && wr_addr == ram_raddr1 ? wr_data : ram_rdata1;
        rsp_valid_d = flush ? 2'b00 : {iss1, iss0};
        rsp_src_d   = {rsp_valid_d[1] & src_q[h1], rsp_valid_d[0] & src_q[head_q]};
        rsp_tag_d   = {rsp_valid_d[1] ? tag_q[h1] : '0, rsp_valid_d[0] ? tag_q[head_q] : '0};
        rsp_data_d  = {rsp_valid_d[1] ? d1 : '0, rsp_valid_d[0] ? d0 : '0};
        count_d     = flush ? '0 : count_q + n_enq - n_deq;
        head_d      = flush ? '0 : head_q + n_deq[PW-1:0];
        tail_d      = flush ? '0 : tail_q + n_enq[PW-1:0];
        rr_d        = &req_valid && ^grant ? ~rr_q : rr_q;
        state_d     = state_q == S_FLUSH ? S_IDLE : flush ? S_FLUSH :
                      count_d != '0 ? S_ACTIVE : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rr_q        <= 1'b0;
            rsp_valid_q <= '0;
            rsp_src_q   <= '0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Requester 0 takes the tail slot first when both are granted.
    always_ff @(posedge clk) begin
        if (grant[0]) begin
            addr_q[tail_q] <= req_addr[ADDR_W-1:0];
            tag_q[tail_q]  <= req_tag[TAG_W-1:0];
            src_q[tail_q]  <= 1'b0;
        end
        if (grant[1]) begin
            addr_q[grant[0] ? t1 : tail_q] <= req_addr[2*ADDR_W-1:ADDR_W];
            tag_q[grant[0] ? t1 : tail_q]  <= req_tag[2*TAG_W-1:TAG_W];
            src_q[grant[0] ? t1 : tail_q]  <= 1'b1;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_data  = rsp_data_q;

`ifdef RAM_SCHED_STATS_EN
    logic [31:0] issued_q, stalls_q;
    logic [32:0] issued_sum;
    assign issued_sum = {1'b0, issued_q} + 33'(n_deq);
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            issued_q <= issued_sum[32] ? '1 : issued_sum[31:0];
            if (|(req_valid & ~req_ready) && stalls_q != '1)
                stalls_q <= stalls_q + 32'd1;
        end
    end
    assign stat_issued = issued_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_issued = '0;
    assign stat_stalls = '0;
`endif
endmodule
